// File: rtl/char_freq_counter.sv
// Character frequency table builder feeding huff_encoder; optional odd-even
// transposition sort by frequency is enabled with the CHAR_FREQ_SORT_EN macro.
module char_freq_counter #(
  parameter int MAX_CHAR_COUNT = 5,
  parameter int CHAR_W         = 8,
  parameter int FREQ_W         = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  input  logic [CHAR_W-1:0]                  in_data,
  input  logic                               in_last,
  output logic                               in_ready,
  output logic [MAX_CHAR_COUNT*CHAR_W-1:0]   char_out,
  output logic [MAX_CHAR_COUNT*FREQ_W-1:0]   freq_out,
  output logic [$clog2(MAX_CHAR_COUNT+1)-1:0] uniq_count,
  output logic                               table_valid,
  output logic                               overflow,
  input  logic                               table_ack
);

  localparam int UC_W = $clog2(MAX_CHAR_COUNT + 1);
  localparam logic [FREQ_W-1:0] FREQ_MAX = {FREQ_W{1'b1}};

`ifdef CHAR_FREQ_SORT_EN
  localparam int SC_W = (MAX_CHAR_COUNT > 1) ? $clog2(MAX_CHAR_COUNT) : 1;
  typedef enum logic [1:0] {COLLECT = 2'd0, SORT = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {COLLECT = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CHAR_W-1:0]   r_char     [MAX_CHAR_COUNT];
  logic [FREQ_W-1:0]   r_freq     [MAX_CHAR_COUNT];
  logic [CHAR_W-1:0]   w_char_nxt [MAX_CHAR_COUNT];
  logic [FREQ_W-1:0]   w_freq_nxt [MAX_CHAR_COUNT];
  logic [UC_W-1:0]     r_uniq;
  logic [UC_W-1:0]     w_uniq_nxt;
  logic                r_ovf;
  logic                w_ovf_nxt;
  logic                r_in_ready;
  logic                w_ready_nxt;
  logic                r_tv;
  logic                w_tv_nxt;
  logic                w_ack;
  logic                w_hit;
  logic [UC_W-1:0]     w_hit_idx;
`ifdef CHAR_FREQ_SORT_EN
  logic [SC_W-1:0]     r_sort_cnt;
  logic [SC_W-1:0]     w_sort_cnt_nxt;
`endif

  assign w_ack = table_ack && r_tv && (r_state == DONE);

  // Lookup is gated by occupancy so that character 0 is an ordinary value.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = {UC_W{1'b0}};
    for (int j = 0; j < MAX_CHAR_COUNT; j++) begin
      if ((UC_W'(j) < r_uniq) && (r_char[j] == in_data)) begin
        w_hit     = 1'b1;
        w_hit_idx = UC_W'(j);
      end else begin
        w_hit     = w_hit;
        w_hit_idx = w_hit_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_char_nxt  = r_char;
    w_freq_nxt  = r_freq;
    w_uniq_nxt  = r_uniq;
    w_ovf_nxt   = r_ovf;
    w_tv_nxt    = 1'b0;
`ifdef CHAR_FREQ_SORT_EN
    w_sort_cnt_nxt = r_sort_cnt;
`endif
    case (r_state)
      COLLECT: begin
        if (in_valid && r_in_ready) begin
          if (w_hit) begin
            if (r_freq[w_hit_idx] != FREQ_MAX) begin
              w_freq_nxt[w_hit_idx] = r_freq[w_hit_idx] + {{(FREQ_W-1){1'b0}}, 1'b1};
            end else begin
              w_freq_nxt[w_hit_idx] = FREQ_MAX;
            end
          end else if (r_uniq < UC_W'(MAX_CHAR_COUNT)) begin
            w_char_nxt[r_uniq] = in_data;
            w_freq_nxt[r_uniq] = {{(FREQ_W-1){1'b0}}, 1'b1};
            w_uniq_nxt         = r_uniq + {{(UC_W-1){1'b0}}, 1'b1};
          end else begin
            w_ovf_nxt = 1'b1;
          end
          if (in_last) begin
`ifdef CHAR_FREQ_SORT_EN
            w_state_nxt = SORT;
`else
            w_state_nxt = DONE;
`endif
          end else begin
            w_state_nxt = COLLECT;
          end
        end else begin
          w_state_nxt = COLLECT;
        end
      end
`ifdef CHAR_FREQ_SORT_EN
      SORT: begin
        // Pairs in one phase are disjoint, so reading registered values is safe.
        for (int i = 0; i < MAX_CHAR_COUNT - 1; i++) begin
          if ((i[0] == r_sort_cnt[0]) && (UC_W'(i + 1) < r_uniq) &&
              (r_freq[i] > r_freq[i+1])) begin
            w_char_nxt[i]   = r_char[i+1];
            w_char_nxt[i+1] = r_char[i];
            w_freq_nxt[i]   = r_freq[i+1];
            w_freq_nxt[i+1] = r_freq[i];
          end else begin
            w_char_nxt[i] = w_char_nxt[i];
          end
        end
        if (r_sort_cnt == SC_W'(MAX_CHAR_COUNT - 1)) begin
          w_sort_cnt_nxt = {SC_W{1'b0}};
          w_state_nxt    = DONE;
        end else begin
          w_sort_cnt_nxt = r_sort_cnt + {{(SC_W-1){1'b0}}, 1'b1};
        end
      end
`endif
      DONE: begin
        if (w_ack) begin
          for (int k = 0; k < MAX_CHAR_COUNT; k++) begin
            w_char_nxt[k] = {CHAR_W{1'b0}};
            w_freq_nxt[k] = {FREQ_W{1'b0}};
          end
          w_uniq_nxt  = {UC_W{1'b0}};
          w_ovf_nxt   = 1'b0;
          w_state_nxt = COLLECT;
        end else begin
          w_tv_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = COLLECT;
      end
    endcase
    w_ready_nxt = (w_state_nxt == COLLECT);
  end

  // table_valid lags entry into DONE by one cycle, giving the documented latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= COLLECT;
      r_uniq     <= {UC_W{1'b0}};
      r_ovf      <= 1'b0;
      r_in_ready <= 1'b0;
      r_tv       <= 1'b0;
`ifdef CHAR_FREQ_SORT_EN
      r_sort_cnt <= {SC_W{1'b0}};
`endif
      for (int k = 0; k < MAX_CHAR_COUNT; k++) begin
        r_char[k] <= {CHAR_W{1'b0}};
        r_freq[k] <= {FREQ_W{1'b0}};
      end
    end else begin
      r_state    <= w_state_nxt;
      r_uniq     <= w_uniq_nxt;
      r_ovf      <= w_ovf_nxt;
      r_in_ready <= w_ready_nxt;
      r_tv       <= w_tv_nxt;
`ifdef CHAR_FREQ_SORT_EN
      r_sort_cnt <= w_sort_cnt_nxt;
`endif
      for (int k = 0; k < MAX_CHAR_COUNT; k++) begin
        r_char[k] <= w_char_nxt[k];
        r_freq[k] <= w_freq_nxt[k];
      end
    end
  end

  for (genvar g = 0; g < MAX_CHAR_COUNT; g++) begin : g_pack
    assign char_out[g*CHAR_W +: CHAR_W] = r_char[g];
    assign freq_out[g*FREQ_W +: FREQ_W] = r_freq[g];
  end

  assign in_ready    = r_in_ready;
  assign uniq_count  = r_uniq;
  assign table_valid = r_tv;
  assign overflow    = r_ovf;

endmodule

// File: doc/char_freq_counter.md
Name: char_freq_counter

Overview:
- Upstream stage of huff_encoder. Accepts a byte-serial message over a valid/ready stream.
- Builds a table of unique characters and their occurrence counts.
- Presents the table as the packed character and frequency vectors that feed huff_encoder's data_in/freq_in.
- Holds the table stable until the consumer acknowledges it, then clears and accepts the next message.

Parameters:
- MAX_CHAR_COUNT, 5, number of table slots (maximum unique characters per message).
- CHAR_W, 8, character width in bits.
- FREQ_W, 3, frequency counter width in bits; counts saturate at 2^FREQ_W-1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  CHAR_W  input character.
- in_last  in  1  qualified by in_valid; marks the final character of the message (that character is counted).
- in_ready  out  1  block accepts a character this cycle.
- char_out  out  MAX_CHAR_COUNT*CHAR_W  slot k at bits [k*CHAR_W +: CHAR_W].
- freq_out  out  MAX_CHAR_COUNT*FREQ_W  slot k at bits [k*FREQ_W +: FREQ_W].
- uniq_count  out  $clog2(MAX_CHAR_COUNT+1)  number of occupied slots.
- table_valid  out  1  table complete and stable.
- overflow  out  1  sticky; at least one new unique character was dropped in this message.
- table_ack  in  1  consumer has taken the table; sampled only while table_valid=1.

Behaviour:
- States: COLLECT, SORT, DONE.
- Reset (reset=0, asynchronous):
  - state=COLLECT; all slots char=0, freq=0.
  - uniq_count=0, table_valid=0, overflow=0, sort counter=0.
  - in_ready is low while reset is asserted; it goes to 1 in the first cycle after deassertion.
- COLLECT:
  - in_ready=1. A character is accepted when in_valid&&in_ready; one character per cycle, no bubbles.
  - Lookup is a combinational match of in_data against occupied slots 0..uniq_count-1.
    - Hit: that slot's freq increments, saturating at 2^FREQ_W-1.
    - Miss with uniq_count<MAX_CHAR_COUNT: write slot[uniq_count] with char=in_data, freq=1; uniq_count increments.
    - Miss with table full: character dropped, overflow<=1, no other change.
  - Character value 0 is a legal character. Matching is qualified by slot occupancy, never by char!=0.
  - Accepted beat with in_last=1: next state SORT (or DONE when the optional feature is disabled). in_ready=0 from the next cycle.
- SORT:
  - Odd-even transposition sort, ascending by freq, over occupied slots only.
  - Exactly MAX_CHAR_COUNT cycles. Cycle p compares pairs (i,i+1) with i even when p is even, i odd when p is odd.
  - A pair swaps char and freq together, only if freq[i] > freq[i+1] (strict compare, so the sort is stable).
  - Empty slots never move.
  - After cycle MAX_CHAR_COUNT-1: next state DONE.
- DONE:
  - table_valid=1; in_ready=0; outputs constant.
  - When table_ack=1: all slots cleared to 0, uniq_count=0, overflow=0, table_valid=0, next state COLLECT. New data is accepted the cycle after the ack.
- Unoccupied slots always read char=0, freq=0.
- Latency:
  - table_valid rises MAX_CHAR_COUNT+1 cycles after the clock edge accepting the in_last beat with sort enabled.
  - It rises 1 cycle after that edge with sort disabled.
- Boundary conditions:
  - table_ack outside DONE is ignored.
  - in_valid outside COLLECT is ignored; no handshake occurs.
  - A message of a single character gives uniq_count=1, freq=1.
  - Reset asserted in any state aborts the message immediately and returns to reset values.

Optional Feature:
- Macro: CHAR_FREQ_SORT_EN.
- Defined: SORT state present; table is delivered in ascending frequency order, ties kept in first-appearance order.
- Undefined: no SORT state; COLLECT goes directly to DONE; table is delivered in first-appearance order; no sort logic is synthesized.

Test Plan:
- Stream "anusha", in_last on the final 'a', sort enabled -> uniq_count=5, overflow=0, slots 0..4 = n,u,s,h,a with freq 1,1,1,1,2; table_valid exactly 6 cycles after the last beat.
- Same stream, sort disabled -> slots a,n,u,s,h with freq 2,1,1,1,1; table_valid 1 cycle after the last beat.
- Stream "abcdef" (MAX_CHAR_COUNT=5) -> uniq_count=5, 'f' absent, overflow=1; after ack, overflow=0 and all slots are 0.
- Nine 'a' then "b" -> freq(a)=7 (saturated), freq(b)=1; sorted output b,a.
- Message "~" with in_last on its only beat -> uniq_count=1, slot0='~' (0x7E) freq=1, remaining slots 0. Hold table_ack=0 for 10 cycles -> outputs stable, in_valid beats not accepted.
- Assert reset after "an" is accepted -> all outputs return to reset values asynchronously; after release, "aabb" yields a,b with freq 2,2 and tie order preserved.
